// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: qualifies channel requests, runs the HRQ/HLDA hold
// handshake and holds a registered one-hot grant for the whole service.
module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] reqSet,
  input  logic [NUM_CH-1:0] maskBits,
  input  logic              cmdDisable,
  input  logic              cmdRotate,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              HLDA,
  input  logic              chDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CHW-1:0]    grantCh
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT} stateT;

  stateT             state;
  stateT             stateNext;
  logic [NUM_CH-1:0] dreqQ;
  logic [NUM_CH-1:0] effReq;
  logic [NUM_CH-1:0] grantOH;
  logic              anyReq;
  logic [CHW-1:0]    lastCh;
  logic [CHW-1:0]    startCh;
  logic [CHW-1:0]    winner;
  logic [CHW:0]      scanIdx;
  logic              found;
  logic              loadGrant;
  logic              clearGrant;
  logic              advancePtr;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gReq
    assign effReq[gi] = ((dreqQ[gi] ^ dreqActiveLow) & ~maskBits[gi]) | reqSet[gi];
  end

  assign anyReq = |effReq;

  // Search origin: channel 0 in fixed mode, the channel after the last served one when rotating.
  always_comb begin
    startCh = '0;
    if (cmdRotate && (lastCh != CHW'(NUM_CH - 1))) begin
      startCh = lastCh + CHW'(1);
    end
  end

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    scanIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scanIdx = {1'b0, startCh} + (CHW+1)'(k);
      if (scanIdx >= (CHW+1)'(NUM_CH)) begin
        scanIdx = scanIdx - (CHW+1)'(NUM_CH);
      end
      if (!found && effReq[scanIdx[CHW-1:0]]) begin
        winner = scanIdx[CHW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    loadGrant  = 1'b0;
    clearGrant = 1'b0;
    advancePtr = 1'b0;
    case (state)
      IDLE: begin
        if (!cmdDisable && anyReq) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        if (cmdDisable || !anyReq) begin
          stateNext = IDLE;
        end else if (HLDA) begin
          stateNext = GRANT;
          loadGrant = 1'b1;
        end
      end
      GRANT: begin
        // chDone wins over a simultaneous loss of HLDA so the pointer still advances.
        if (chDone) begin
          stateNext  = IDLE;
          clearGrant = 1'b1;
          advancePtr = cmdRotate;
        end else if (!HLDA) begin
          stateNext  = IDLE;
          clearGrant = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      dreqQ      <= '0;
      grantOH    <= '0;
      grantCh    <= '0;
      grantValid <= 1'b0;
      HRQ        <= 1'b0;
      lastCh     <= CHW'(NUM_CH - 1);
    end else begin
      state      <= stateNext;
      dreqQ      <= DREQ;
      HRQ        <= (stateNext != IDLE);
      grantValid <= (stateNext == GRANT);
      if (loadGrant) begin
        grantCh <= winner;
        grantOH <= {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
      end else if (clearGrant) begin
        grantOH <= '0;
      end
      if (!cmdRotate) begin
        lastCh <= CHW'(NUM_CH - 1);
      end else if (advancePtr) begin
        lastCh <= grantCh;
      end
    end
  end

  assign DACK = grantOH ^ {NUM_CH{~dackActiveHigh}};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: directed stimulus queues expected
// grants, per-instance monitors pop and compare on each new grant.
module tb_dma_channel_arbiter;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0] d4Dreq, d4ReqSet, d4Mask, d4Dack;
  logic       d4Disable, d4Rotate, d4DreqLow, d4DackHigh, d4Hlda, d4Done;
  logic       d4Hrq, d4Gv;
  logic [1:0] d4Ch;

  logic [7:0] d8Dreq, d8ReqSet, d8Mask, d8Dack;
  logic       d8Disable, d8Rotate, d8DreqLow, d8DackHigh, d8Hlda, d8Done;
  logic       d8Hrq, d8Gv;
  logic [2:0] d8Ch;

  dma_channel_arbiter #(.NUM_CH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .DREQ(d4Dreq), .reqSet(d4ReqSet), .maskBits(d4Mask),
    .cmdDisable(d4Disable), .cmdRotate(d4Rotate), .dreqActiveLow(d4DreqLow),
    .dackActiveHigh(d4DackHigh), .HLDA(d4Hlda), .chDone(d4Done),
    .HRQ(d4Hrq), .DACK(d4Dack), .grantValid(d4Gv), .grantCh(d4Ch)
  );

  dma_channel_arbiter #(.NUM_CH(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .DREQ(d8Dreq), .reqSet(d8ReqSet), .maskBits(d8Mask),
    .cmdDisable(d8Disable), .cmdRotate(d8Rotate), .dreqActiveLow(d8DreqLow),
    .dackActiveHigh(d8DackHigh), .HLDA(d8Hlda), .chDone(d8Done),
    .HRQ(d8Hrq), .DACK(d8Dack), .grantValid(d8Gv), .grantCh(d8Ch)
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] dack;
  } expT;

  expT q4[$];
  expT q8[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // which: 0 = dut4 HRQ, 1 = dut4 grantValid, 2 = dut8 HRQ, 3 = dut8 grantValid
  task automatic waitFor(input string name, input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      case (which)
        0:       seen = d4Hrq;
        1:       seen = d4Gv;
        2:       seen = d8Hrq;
        default: seen = d8Gv;
      endcase
    end
    check({name, " wait"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic grant4(input logic [2:0] ch, input logic [7:0] dack, input int delay);
    q4.push_back('{ch, dack});
    waitFor("dut4 HRQ", 0);
    repeat (delay) tick();
    d4Hlda = 1'b1;
    waitFor("dut4 grantValid", 1);
  endtask

  task automatic done4();
    d4Done = 1'b1;
    d4Hlda = 1'b0;
    tick();
    d4Done = 1'b0;
    check("done HRQ", {31'd0, d4Hrq}, 32'd0);
    check("done grantValid", {31'd0, d4Gv}, 32'd0);
    check("done DACK", {28'd0, d4Dack}, 32'hF);
  endtask

  task automatic busLoss4();
    d4Hlda = 1'b0;
    tick();
    check("busloss HRQ", {31'd0, d4Hrq}, 32'd0);
    check("busloss grantValid", {31'd0, d4Gv}, 32'd0);
    check("busloss DACK", {28'd0, d4Dack}, 32'hF);
  endtask

  initial begin : mon4
    logic prev;
    expT  e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (d4Gv && !prev) begin
        if (q4.size() == 0) begin
          check("dut4 queued grants", 32'(q4.size()), 32'd1);
        end else begin
          e = q4.pop_front();
          $display("dut4 grant ch=%0d dack=%b (expected ch=%0d dack=%b)", d4Ch, d4Dack, e.ch, e.dack[3:0]);
          check("dut4 grantCh", {30'd0, d4Ch}, {29'd0, e.ch});
          check("dut4 DACK", {28'd0, d4Dack}, {28'd0, e.dack[3:0]});
        end
      end
      prev = d4Gv;
    end
  end

  initial begin : mon8
    logic prev;
    expT  e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (d8Gv && !prev) begin
        if (q8.size() == 0) begin
          check("dut8 queued grants", 32'(q8.size()), 32'd1);
        end else begin
          e = q8.pop_front();
          $display("dut8 grant ch=%0d dack=%b (expected ch=%0d dack=%b)", d8Ch, d8Dack, e.ch, e.dack);
          check("dut8 grantCh", {29'd0, d8Ch}, {29'd0, e.ch});
          check("dut8 DACK", {24'd0, d8Dack}, {24'd0, e.dack});
        end
      end
      prev = d8Gv;
    end
  end

  initial begin : stim
    logic [2:0] rotCh   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [7:0] rotDack [5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFE};
    logic       sawHrq;

    d4Dreq = '0; d4ReqSet = '0; d4Mask = '0;
    d4Disable = 0; d4Rotate = 0; d4DreqLow = 0; d4DackHigh = 0; d4Hlda = 0; d4Done = 0;
    d8Dreq = '0; d8ReqSet = '0; d8Mask = '0;
    d8Disable = 0; d8Rotate = 0; d8DreqLow = 0; d8DackHigh = 0; d8Hlda = 0; d8Done = 0;

    repeat (3) @(posedge CLK);
    #1;
    check("reset HRQ4", {31'd0, d4Hrq}, 32'd0);
    check("reset grantValid4", {31'd0, d4Gv}, 32'd0);
    check("reset grantCh4", {30'd0, d4Ch}, 32'd0);
    check("reset DACK4", {28'd0, d4Dack}, 32'hF);
    check("reset DACK8", {24'd0, d8Dack}, 32'hFF);
    RESET = 1'b0;
    tick();

    // Fixed priority with active-low DACK
    d4Dreq = 4'b1010;
    grant4(3'd1, 8'hFD, 3);
    d4DackHigh = 1'b1;
    #1;
    check("DACK active high", {28'd0, d4Dack}, 32'b0010);
    d4DackHigh = 1'b0;
    #1;
    done4();
    grant4(3'd1, 8'hFD, 0);
    d4Dreq = 4'b0000;
    done4();
    tick();

    // Rotation with wrap-around
    d4Rotate = 1'b1;
    d4Dreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      grant4(rotCh[i], rotDack[i], 0);
      if (i == 4) d4Dreq = 4'b0000;
      done4();
    end
    tick();

    // Masked DREQ is ignored, software request is not
    d4Rotate = 1'b0;
    d4Mask = 4'b0001;
    d4Dreq = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("masked HRQ", {31'd0, d4Hrq}, 32'd0);
    end
    d4ReqSet = 4'b0100;
    q4.push_back('{3'd2, 8'hFB});
    tick();
    check("reqSet HRQ latency", {31'd0, d4Hrq}, 32'd1);
    d4Hlda = 1'b1;
    waitFor("dut4 grantValid", 1);
    d4ReqSet = 4'b0000;
    d4Dreq = 4'b0000;
    d4Mask = 4'b0000;
    done4();
    tick();
    tick();

    // Withdrawn request
    d4Dreq = 4'b1000;
    tick();
    tick();
    d4Dreq = 4'b0000;
    sawHrq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sawHrq |= d4Hrq;
      check("withdraw DACK", {28'd0, d4Dack}, 32'hF);
    end
    check("withdraw saw HRQ", {31'd0, sawHrq}, 32'd1);
    check("withdraw HRQ", {31'd0, d4Hrq}, 32'd0);
    check("withdraw grantValid", {31'd0, d4Gv}, 32'd0);

    // Disabled controller
    d4Disable = 1'b1;
    d4Dreq = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("disabled HRQ", {31'd0, d4Hrq}, 32'd0);
    end
    d4Dreq = 4'b0000;
    tick();
    tick();
    d4Disable = 1'b0;
    tick();

    // Bus loss leaves the rotation pointer untouched
    d4Rotate = 1'b1;
    d4Dreq = 4'b0001;
    grant4(3'd0, 8'hFE, 0);
    d4Dreq = 4'b0100;
    done4();
    grant4(3'd2, 8'hFB, 0);
    d4Dreq = 4'b0110;
    busLoss4();
    grant4(3'd1, 8'hFD, 0);
    d4Dreq = 4'b1000;
    done4();
    grant4(3'd3, 8'hF7, 0);
    d4Dreq = 4'b1001;
    busLoss4();
    grant4(3'd3, 8'hF7, 0);
    d4Dreq = 4'b0000;
    done4();
    tick();

    // Asynchronous reset in the middle of a grant
    d4Rotate = 1'b0;
    d4Dreq = 4'b0100;
    grant4(3'd2, 8'hFB, 0);
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("async reset HRQ", {31'd0, d4Hrq}, 32'd0);
    check("async reset DACK", {28'd0, d4Dack}, 32'hF);
    check("async reset grantValid", {31'd0, d4Gv}, 32'd0);
    d4Hlda = 1'b0;
    d4Dreq = 4'b0000;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    tick();

    // Eight-channel instance, highest channel
    d8Dreq = 8'h80;
    q8.push_back('{3'd7, 8'h7F});
    waitFor("dut8 HRQ", 2);
    d8Hlda = 1'b1;
    waitFor("dut8 grantValid", 3);
    d8Dreq = 8'h00;
    d8Done = 1'b1;
    d8Hlda = 1'b0;
    tick();
    d8Done = 1'b0;
    check("dut8 done DACK", {24'd0, d8Dack}, 32'hFF);
    check("dut8 done HRQ", {31'd0, d8Hrq}, 32'd0);

    repeat (3) tick();
    check("dut4 leftover expectations", 32'(q4.size()), 32'd0);
    check("dut8 leftover expectations", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
